// File: rtl/wb_stage.sv
// Write-back stage: load alignment, register-file write port, post-WB
// forwarding registers and the retired-instruction counter.
module wb_stage #(
   parameter int unsigned CWIDTH = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_ld_wb,
   input  logic [2:0]        ld_code_wb,
   input  logic [4:0]        rd_adr_wb,
   input  logic [31:0]       rd_data_wb,
   input  logic              wbk_rd_reg_wb,
   input  logic [31:0]       ld_data_wb,
   input  logic              inst_rtr_wb,
   input  logic              stall,
   input  logic              rst_pipe,
   input  logic              instret_clr,
   output logic              wbk_we,
   output logic [4:0]        wbk_adr,
   output logic [31:0]       wbk_data,
   output logic              fw_we_wb1,
   output logic [4:0]        fw_adr_wb1,
   output logic [31:0]       fw_data_wb1,
   output logic [CWIDTH-1:0] instret
);

   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [31:0]       ld_aligned;

   logic              fw_we_q,   fw_we_d;
   logic [4:0]        fw_adr_q,  fw_adr_d;
   logic [31:0]       fw_data_q, fw_data_d;
   logic [CWIDTH-1:0] instret_q, instret_d;

   always_comb begin
      ld_byte = 8'(ld_data_wb >> {rd_data_wb[1:0], 3'b000});
      ld_half = rd_data_wb[1] ? ld_data_wb[31:16] : ld_data_wb[15:0];
      case (ld_code_wb)
         3'b000:  ld_aligned = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_aligned = {{16{ld_half[15]}}, ld_half};
         3'b010:  ld_aligned = ld_data_wb;
         3'b100:  ld_aligned = {24'd0, ld_byte};
         3'b101:  ld_aligned = {16'd0, ld_half};
         default: ld_aligned = '0;
      endcase
   end

   // Stall alone gates the write; a flush never blocks the older WB instruction.
   assign wbk_we   = wbk_rd_reg_wb & ~stall & (rd_adr_wb != 5'd0);
   assign wbk_adr  = rd_adr_wb;
   assign wbk_data = cmd_ld_wb ? ld_aligned : rd_data_wb;

   always_comb begin
      fw_we_d   = fw_we_q;
      fw_adr_d  = fw_adr_q;
      fw_data_d = fw_data_q;
      if (rst_pipe) begin
         fw_we_d   = 1'b0;
         fw_adr_d  = '0;
         fw_data_d = '0;
      end else if (!stall) begin
         fw_we_d   = wbk_we;
         fw_adr_d  = wbk_adr;
         fw_data_d = wbk_data;
      end
   end

   always_comb begin
      instret_d = instret_q;
      if (instret_clr)
         instret_d = '0;
      else if (inst_rtr_wb && !stall)
         instret_d = instret_q + CWIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fw_we_q   <= 1'b0;
         fw_adr_q  <= '0;
         fw_data_q <= '0;
         instret_q <= '0;
      end else begin
         fw_we_q   <= fw_we_d;
         fw_adr_q  <= fw_adr_d;
         fw_data_q <= fw_data_d;
         instret_q <= instret_d;
      end
   end

   assign fw_we_wb1   = fw_we_q;
   assign fw_adr_wb1  = fw_adr_q;
   assign fw_data_wb1 = fw_data_q;
   assign instret     = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a stimulus process pushes expected outputs
// from a reference model, a monitor pops and compares on each falling edge.
module tb_wb_stage;

   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_ld_wb;
   logic [2:0]    ld_code_wb;
   logic [4:0]    rd_adr_wb;
   logic [31:0]   rd_data_wb;
   logic          wbk_rd_reg_wb;
   logic [31:0]   ld_data_wb;
   logic          inst_rtr_wb;
   logic          stall;
   logic          rst_pipe;
   logic          instret_clr;
   logic          wbk_we;
   logic [4:0]    wbk_adr;
   logic [31:0]   wbk_data;
   logic          fw_we_wb1;
   logic [4:0]    fw_adr_wb1;
   logic [31:0]   fw_data_wb1;
   logic [CW-1:0] instret;

   wb_stage #(.CWIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_ld_wb(cmd_ld_wb), .ld_code_wb(ld_code_wb),
      .rd_adr_wb(rd_adr_wb), .rd_data_wb(rd_data_wb), .wbk_rd_reg_wb(wbk_rd_reg_wb),
      .ld_data_wb(ld_data_wb), .inst_rtr_wb(inst_rtr_wb), .stall(stall),
      .rst_pipe(rst_pipe), .instret_clr(instret_clr), .wbk_we(wbk_we),
      .wbk_adr(wbk_adr), .wbk_data(wbk_data), .fw_we_wb1(fw_we_wb1),
      .fw_adr_wb1(fw_adr_wb1), .fw_data_wb1(fw_data_wb1), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  adr;
      logic [31:0] data;
      logic        fwe;
      logic [4:0]  fadr;
      logic [31:0] fdata;
      int unsigned cnt;
   } exp_t;

   exp_t expq[$];
   int unsigned passed = 0;
   int unsigned total  = 0;

   // Reference state: the last committed write and the retire count.
   logic        m_fwe;
   logic [4:0]  m_fadr;
   logic [31:0] m_fdata;
   int unsigned m_cnt;

   function automatic logic [31:0] ref_load(input logic [2:0] code,
                                            input logic [31:0] ld,
                                            input logic [31:0] addr);
      int unsigned ofs = addr % 4;
      int unsigned b   = (ld >> (8 * ofs)) % 256;
      int unsigned h   = ((addr % 4) >= 2) ? (ld >> 16) : (ld % 65536);
      case (code)
         3'd0:    return (b >= 128) ? 32'(int'(b) - 256) : 32'(b);
         3'd1:    return (h >= 32768) ? 32'(int'(h) - 65536) : 32'(h);
         3'd2:    return ld;
         3'd4:    return 32'(b);
         3'd5:    return 32'(h);
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (expq.size() > 0) begin
         exp_t e;
         e = expq.pop_front();
         chk("wbk_we",      32'(wbk_we),      32'(e.we));
         chk("wbk_adr",     32'(wbk_adr),     32'(e.adr));
         chk("wbk_data",    wbk_data,         e.data);
         chk("fw_we_wb1",   32'(fw_we_wb1),   32'(e.fwe));
         chk("fw_adr_wb1",  32'(fw_adr_wb1),  32'(e.fadr));
         chk("fw_data_wb1", fw_data_wb1,      e.fdata);
         chk("instret",     32'(instret),     e.cnt);
      end
   end

   task automatic step(input logic rn, input logic ld, input logic [2:0] code,
                       input logic [4:0] adr, input logic [31:0] data,
                       input logic wr, input logic [31:0] lddat, input logic rtr,
                       input logic stl, input logic pipe, input logic clr);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = rn; cmd_ld_wb = ld; ld_code_wb = code; rd_adr_wb = adr;
      rd_data_wb = data; wbk_rd_reg_wb = wr; ld_data_wb = lddat;
      inst_rtr_wb = rtr; stall = stl; rst_pipe = pipe; instret_clr = clr;
      if (!rn) begin
         m_fwe = 1'b0; m_fadr = '0; m_fdata = '0; m_cnt = 0;
      end
      e.we    = wr && !stl && adr != 0;
      e.adr   = adr;
      e.data  = ld ? ref_load(code, lddat, data) : data;
      e.fwe   = m_fwe;
      e.fadr  = m_fadr;
      e.fdata = m_fdata;
      e.cnt   = m_cnt;
      expq.push_back(e);
      if (rn) begin
         if (pipe) begin
            m_fwe = 1'b0; m_fadr = '0; m_fdata = '0;
         end else if (!stl) begin
            m_fwe = e.we; m_fadr = e.adr; m_fdata = e.data;
         end
         if (clr) m_cnt = 0;
         else if (rtr && !stl) m_cnt = (m_cnt + 1) % (1 << CW);
      end
   endtask

   task automatic idle();
      step(1, 0, 3'd0, 5'd0, 32'd0, 0, 32'd0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 0; cmd_ld_wb = 0; ld_code_wb = 0; rd_adr_wb = 0; rd_data_wb = 0;
      wbk_rd_reg_wb = 0; ld_data_wb = 0; inst_rtr_wb = 0; stall = 0;
      rst_pipe = 0; instret_clr = 0;
      m_fwe = 0; m_fadr = 0; m_fdata = 0; m_cnt = 0;

      step(0, 0, 3'd0, 5'd0, 32'd0, 0, 32'd0, 0, 0, 0, 0);
      step(0, 0, 3'd0, 5'd0, 32'd0, 0, 32'd0, 0, 0, 0, 0);

      // Load alignment vectors
      step(1, 1, 3'd0, 5'd3, 32'h1000_0002, 1, 32'h80FF7F01, 1, 0, 0, 0);
      step(1, 1, 3'd4, 5'd3, 32'h1000_0002, 1, 32'h80FF7F01, 1, 0, 0, 0);
      step(1, 1, 3'd0, 5'd3, 32'h1000_0001, 1, 32'h80FF7F01, 1, 0, 0, 0);
      step(1, 1, 3'd4, 5'd3, 32'h1000_0003, 1, 32'h80FF7F01, 1, 0, 0, 0);
      step(1, 1, 3'd1, 5'd4, 32'h2000_0002, 1, 32'h80001234, 1, 0, 0, 0);
      step(1, 1, 3'd5, 5'd4, 32'h2000_0002, 1, 32'h80001234, 1, 0, 0, 0);
      step(1, 1, 3'd1, 5'd4, 32'h2000_0000, 1, 32'h80001234, 1, 0, 0, 0);
      step(1, 1, 3'd2, 5'd4, 32'h2000_0003, 1, 32'h80001234, 1, 0, 0, 0);
      step(1, 1, 3'd7, 5'd4, 32'h2000_0000, 1, 32'h80001234, 1, 0, 0, 0);

      // Stalled ALU write: held three cycles, then one write
      for (int i = 0; i < 3; i++)
         step(1, 0, 3'd0, 5'd5, 32'hDEADBEEF, 1, 32'h0, 1, 1, 0, 0);
      step(1, 0, 3'd0, 5'd5, 32'hDEADBEEF, 1, 32'h0, 1, 0, 0, 0);
      idle();
      idle();

      // Write to x0 is suppressed
      step(1, 0, 3'd0, 5'd0, 32'h12345678, 1, 32'h0, 1, 0, 0, 0);
      idle();

      // Counter wrap and clear priority
      step(1, 0, 3'd0, 5'd0, 32'h0, 0, 32'h0, 0, 0, 0, 1);
      for (int i = 0; i < 14; i++)
         step(1, 0, 3'd0, 5'd1, 32'(i), 1, 32'h0, 1, 0, 0, 0);
      step(1, 0, 3'd0, 5'd1, 32'h0, 1, 32'h0, 1, 0, 0, 0);
      step(1, 0, 3'd0, 5'd1, 32'h0, 1, 32'h0, 1, 0, 0, 0);
      step(1, 0, 3'd0, 5'd2, 32'h0, 1, 32'h0, 1, 0, 0, 0);
      step(1, 0, 3'd0, 5'd2, 32'h0, 1, 32'h0, 1, 0, 0, 1);
      idle();

      // Flush with a pending write: write issues, forwarding clears, commit counts
      step(1, 0, 3'd0, 5'd9, 32'hCAFEF00D, 1, 32'h0, 1, 0, 1, 0);
      step(1, 0, 3'd0, 5'd9, 32'h0BADF00D, 1, 32'h0, 1, 0, 0, 0);
      step(1, 0, 3'd0, 5'd9, 32'h0, 0, 32'h0, 0, 1, 1, 0);
      idle();

      // Async reset in the middle of a stall
      step(1, 0, 3'd0, 5'd7, 32'h55AA55AA, 1, 32'h0, 1, 0, 0, 0);
      step(1, 0, 3'd0, 5'd8, 32'h11111111, 1, 32'h0, 1, 1, 0, 0);
      step(0, 0, 3'd0, 5'd8, 32'h11111111, 0, 32'h0, 1, 1, 0, 0);
      idle();

      for (int i = 0; i < 400; i++) begin
         logic rn;
         rn = ($urandom_range(0, 49) != 0);
         step(rn, 1'($urandom_range(0, 1)), 3'($urandom), 5'($urandom), $urandom,
              rn & 1'($urandom_range(0, 3) != 0), $urandom,
              1'($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 3),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
      end

      repeat (3) @(negedge clk);
      if (expq.size() != 0) begin
         total++;
         $display("FAIL drain: got %0d pending expected 0", expq.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter CWIDTH, default 64: width of the retired-instruction counter.
REQ-002 Clock and reset ports are clk and rst_n; one clock; rst_n is asynchronous and active-low.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cmd_ld_wb  input  1  WB instruction is a load.
REQ-006 ld_code_wb  input  3  load type (funct3): 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-007 rd_adr_wb  input  5  destination register index.
REQ-008 rd_data_wb  input  32  ALU result, or effective address for loads.
REQ-009 wbk_rd_reg_wb  input  1  instruction writes rd.
REQ-010 ld_data_wb  input  32  raw 32-bit word read by the memory-access stage.
REQ-011 inst_rtr_wb  input  1  valid instruction occupies WB.
REQ-012 stall  input  1  pipeline stall.
REQ-013 rst_pipe  input  1  pipeline flush.
REQ-014 instret_clr  input  1  synchronous clear of the retire counter.
REQ-015 wbk_we  output  1  register-file write enable (combinational).
REQ-016 wbk_adr  output  5  register-file write index (combinational).
REQ-017 wbk_data  output  32  register-file write data (combinational).
REQ-018 fw_we_wb1, fw_adr_wb1, fw_data_wb1  output  1/5/32  registered copy of the last committed write, for post-WB bypass to the decode/execute stages.
REQ-019 instret  output  CWIDTH  retired-instruction count.

Function
REQ-020 Byte offset ofs = rd_data_wb[1:0]; half offset = rd_data_wb[1].
REQ-021 LB: byte ld_data_wb[8*ofs+7:8*ofs], sign-extended to 32 bits; LBU: the same byte, zero-extended.
REQ-022 LH: halfword ld_data_wb[31:16] if rd_data_wb[1] is 1, else [15:0], sign-extended; LHU: the same halfword, zero-extended.
REQ-023 LW: ld_data_wb passed unchanged; rd_data_wb[1:0] is ignored.
REQ-024 Any other ld_code_wb with cmd_ld_wb=1: aligned data = 32'd0.
REQ-025 wbk_data = aligned load data when cmd_ld_wb=1, else rd_data_wb.
REQ-026 wbk_adr = rd_adr_wb.
REQ-027 wbk_we = wbk_rd_reg_wb & ~stall & (rd_adr_wb != 0); writes to x0 are never issued.
REQ-028 A stalled instruction writes exactly once: on the first cycle stall is low while it is in WB.
REQ-029 rst_pipe does not block the write of the instruction currently in WB, because that instruction is older than the flush point.
REQ-030 Forwarding registers: on each clock edge with stall=0, fw_we_wb1 <= wbk_we, fw_adr_wb1 <= wbk_adr, fw_data_wb1 <= wbk_data.
REQ-031 Forwarding registers hold their value while stall=1.
REQ-032 rst_pipe=1 clears all forwarding registers to 0; rst_pipe has priority over stall.
REQ-033 Commit is defined as inst_rtr_wb & ~stall.
REQ-034 instret increments by 1 per commit, with latency of one clock: the new value is visible the cycle after the commit.
REQ-035 instret wraps from all-ones to 0 with no flag.
REQ-036 instret_clr=1 sets instret to 0 on the next edge; clear wins over a simultaneous commit.
REQ-037 rst_pipe does not affect instret, and a commit in the flush cycle counts.
REQ-038 Load latency: none inside this block; ld_data_wb is consumed in the same cycle it arrives.

Reset
REQ-039 While rst_n=0: fw_we_wb1=0, fw_adr_wb1=0, fw_data_wb1=0 and instret=0, independent of clk.
REQ-040 Combinational outputs follow their inputs during reset; upstream guarantees wbk_rd_reg_wb=0 while rst_n=0.
REQ-041 A reset mid-stall discards the held forwarding state.

Verification
REQ-042 LB, ld_data_wb=0x80FF7F01, rd_data_wb=0x...2 -> wbk_data=0xFFFFFFFF; same stimulus as LBU -> 0x000000FF; with ofs=1 -> 0x0000007F.
REQ-043 LH, ld_data_wb=0x80001234, rd_data_wb[1]=1 -> wbk_data=0xFFFF8000; LHU -> 0x00008000; LW -> 0x80001234.
REQ-044 ALU write rd=5, data=0xDEADBEEF, stall high for 3 cycles -> wbk_we=0 for those 3 cycles, then 1 for exactly one cycle; fw_data_wb1=0xDEADBEEF one cycle later.
REQ-045 Write with rd=0 -> wbk_we=0, fw_we_wb1=0.
REQ-046 instret preset near all-ones, 2 commits -> instret = all-ones, then 0; commit and instret_clr in the same cycle -> instret=0.
REQ-047 rst_pipe asserted during a pending write -> write issues, fw registers read 0 next cycle; rst_n asserted mid-stall -> all registered outputs 0 immediately.
